// File: rtl/mskaes_round_sequencer_if.sv
// Handshake and control bundle between the masked AES round sequencer
// and its datapath/host; master is the sequencer side.
interface mskaes_round_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       load_init;
  logic       round_en;
  logic       last_round;
  logic       cleaning_on;
  logic       rnd_valid;
  logic [7:0] rcon;
  logic [3:0] round_idx;

  modport master (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output load_init,
    output round_en,
    output last_round,
    output cleaning_on,
    output rnd_valid,
    output rcon,
    output round_idx
  );

  modport slave (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  load_init,
    input  round_en,
    input  last_round,
    input  cleaning_on,
    input  rnd_valid,
    input  rcon,
    input  round_idx
  );
endinterface

// File: rtl/mskaes_round_sequencer.sv
// Control sequencer for the iterative masked AES-128 round datapath.
// MSKAES_SEQ_CLEANING_EN adds a CLEAN flush state (also the reset state).
module mskaes_round_sequencer #(
  parameter int LATENCY = 6,
  parameter int NR      = 10,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mskaes_round_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
`ifdef MSKAES_SEQ_CLEANING_EN
    , CLEAN
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NR);

`ifdef MSKAES_SEQ_CLEANING_EN
  localparam state_t RST_ST    = CLEAN;
  localparam logic   RST_READY = 1'b0;
  localparam logic   RST_RND   = 1'b1;
`else
  localparam state_t RST_ST    = IDLE;
  localparam logic   RST_READY = 1'b1;
  localparam logic   RST_RND   = 1'b0;
`endif

  state_t           st;
  state_t           st_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [3:0]       idx;
  logic [3:0]       idx_n;
  logic [7:0]       rcon;
  logic [7:0]       rcon_n;

  logic in_ready_q;
  logic out_valid_q;
  logic round_en_q;
  logic last_q;
  logic rnd_q;
  logic rnd_n;
`ifdef MSKAES_SEQ_CLEANING_EN
  logic clean_q;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Next-state, counter, round index and round constant
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    idx_n  = idx;
    rcon_n = rcon;
    unique case (st)
      IDLE: begin
        if (bus.in_valid) begin
          st_n   = RUN;
          cnt_n  = '0;
          idx_n  = 4'd1;
          rcon_n = 8'h01;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            st_n   = DONE;
            idx_n  = 4'd0;
            rcon_n = 8'h00;
          end else begin
            idx_n  = idx + 4'd1;
            rcon_n = xtime(rcon);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
`ifdef MSKAES_SEQ_CLEANING_EN
          st_n  = CLEAN;
          cnt_n = '0;
`else
          st_n  = IDLE;
`endif
        end
      end
`ifdef MSKAES_SEQ_CLEANING_EN
      CLEAN: begin
        if (cnt == CNT_LAST) begin
          st_n  = IDLE;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif
      default: begin
        st_n   = IDLE;
        cnt_n  = '0;
        idx_n  = 4'd0;
        rcon_n = 8'h00;
      end
    endcase
  end

  // Randomness is requested while rounds run and while flushing
  always_comb begin
    rnd_n = (st_n == RUN);
`ifdef MSKAES_SEQ_CLEANING_EN
    if (st_n == CLEAN) rnd_n = 1'b1;
`endif
  end

  // State registers and outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= RST_ST;
      cnt         <= '0;
      idx         <= 4'd0;
      rcon        <= 8'h00;
      in_ready_q  <= RST_READY;
      out_valid_q <= 1'b0;
      round_en_q  <= 1'b0;
      last_q      <= 1'b0;
      rnd_q       <= RST_RND;
`ifdef MSKAES_SEQ_CLEANING_EN
      clean_q     <= 1'b1;
`endif
    end else begin
      st          <= st_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      rcon        <= rcon_n;
      in_ready_q  <= (st_n == IDLE);
      out_valid_q <= (st_n == DONE);
      round_en_q  <= (st_n == RUN) && (cnt_n == CNT_LAST);
      last_q      <= (st_n == RUN) && (idx_n == IDX_LAST);
      rnd_q       <= rnd_n;
`ifdef MSKAES_SEQ_CLEANING_EN
      clean_q     <= (st_n == CLEAN);
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.load_init  = bus.in_valid & in_ready_q;
  assign bus.round_en   = round_en_q;
  assign bus.last_round = last_q;
  assign bus.rnd_valid  = rnd_q;
  assign bus.rcon       = rcon;
  assign bus.round_idx  = idx;
`ifdef MSKAES_SEQ_CLEANING_EN
  assign bus.cleaning_on = clean_q;
`else
  assign bus.cleaning_on = 1'b0;
`endif

endmodule

// File: tb/tb_mskaes_round_sequencer.sv
// Scoreboard bench for mskaes_round_sequencer: default DUT (NR=10,
// LATENCY=6) plus a reduced-round DUT (NR=2, LATENCY=1).
module tb_mskaes_round_sequencer;

  localparam int L   = 6;
  localparam int NR  = 10;
  localparam int L2  = 1;
  localparam int NR2 = 2;

`ifdef MSKAES_SEQ_CLEANING_EN
  localparam logic [18:0] RST_EXP = {7'b000_0011, 8'h00, 4'h0};
  localparam int CLEAN_N  = L;
  localparam int GAP2     = 5;
`else
  localparam logic [18:0] RST_EXP = {7'b100_0000, 8'h00, 4'h0};
  localparam int CLEAN_N  = 0;
  localparam int GAP2     = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mskaes_round_sequencer_if bus ();
  mskaes_round_sequencer_if bus2 ();

  mskaes_round_sequencer #(.LATENCY(L), .NR(NR), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mskaes_round_sequencer #(.LATENCY(L2), .NR(NR2), .CNT_W(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int          exp_out[$];
  logic [12:0] exp_rnd[$];
  int          exp_out2[$];

  logic [7:0] rtab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                            8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  logic [18:0] o1;
  logic [18:0] o2;
  assign o1 = {bus.in_ready, bus.out_valid, bus.load_init, bus.round_en,
               bus.last_round, bus.cleaning_on, bus.rnd_valid,
               bus.rcon, bus.round_idx};
  assign o2 = {bus2.in_ready, bus2.out_valid, bus2.load_init,
               bus2.round_en, bus2.last_round, bus2.cleaning_on,
               bus2.rnd_valid, bus2.rcon, bus2.round_idx};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_block(input int a);
    exp_out.push_back(a + NR * L);
    for (int i = 0; i < NR; i++)
      exp_rnd.push_back({(i == NR - 1), 4'(i + 1), rtab[i]});
  endtask

  always @(posedge clk) cyc++;

  logic [12:0] e;
  logic        ov_q = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.round_en) begin
        if (exp_rnd.size() == 0) chk("round_en unexpected", bus.round_en, 0);
        else begin
          e = exp_rnd.pop_front();
          chk("round last/idx/rcon", {bus.last_round, bus.round_idx, bus.rcon}, e);
        end
      end
      if (bus.out_valid && !ov_q) begin
        if (exp_out.size() == 0) chk("out_valid unexpected", bus.out_valid, 0);
        else chk("out_valid latency edge", cyc, exp_out.pop_front());
      end
      ov_q = bus.out_valid;
    end else begin
      ov_q = 1'b0;
    end
  end

  logic ov2_q = 1'b0;
  int   acc2 = 0;
  int   prev2 = -1;
  int   cl2_seen = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus2.load_init) begin
        exp_out2.push_back(cyc + 1 + NR2 * L2);
        if (prev2 >= 0) chk("dut2 accept spacing", cyc - prev2, GAP2);
        prev2 = cyc;
        acc2++;
      end
      if (bus2.out_valid && !ov2_q) begin
        if (exp_out2.size() == 0) chk("dut2 out_valid unexpected", bus2.out_valid, 0);
        else chk("dut2 out_valid latency edge", cyc, exp_out2.pop_front());
      end
      ov2_q = bus2.out_valid;
      if (bus2.cleaning_on && prev2 >= 0) cl2_seen++;
    end else begin
      ov2_q = 1'b0;
    end
  end

  task automatic count_clean(input string name);
    int n;
    int k;
    n = 0;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (bus.cleaning_on) n++;
      k++;
    end
    chk({name, " cleaning cycles"}, n, CLEAN_N);
    chk({name, " in_ready after flush"}, bus.in_ready, 1);
  endtask

  task automatic send_main();
    int k;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (bus.in_ready) break;
      k++;
    end
    chk("load_init on accept", bus.load_init, 1);
    push_block(cyc + 1);
  endtask

  task automatic wait_out(output int li_seen);
    int k;
    li_seen = 0;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.load_init) li_seen++;
      k++;
    end
    chk("out_valid reached", bus.out_valid, 1);
  endtask

  initial begin
    logic [18:0] snap;
    int          stable;
    int          li;
    int          k;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", o1, RST_EXP);
    chk("dut2 reset outputs", o2, RST_EXP);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus2.out_ready = 1'b1;
    count_clean("post-reset");

    send_main();
    wait_out(li);
    repeat (3) begin
      @(negedge clk);
      if (bus.load_init) li++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("no load_init in RUN/DONE", li, 0);
    chk("done rcon/idx zero", {bus.rcon, bus.round_idx}, 0);

    @(negedge clk);
    snap = o1;
    stable = 1;
    repeat (20) begin
      @(negedge clk);
      if (o1 !== snap) stable = 0;
    end
    chk("done outputs stable", stable, 1);
    chk("done out_valid held", bus.out_valid, 1);

    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    count_clean("post-handshake");

    send_main();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (bus.round_idx == 4'd4) break;
      k++;
    end
    chk("round 4 reached", bus.round_idx, 4);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort reset outputs", o1, RST_EXP);
    exp_out.delete();
    exp_rnd.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_clean("post-abort");

    send_main();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(li);
    repeat (3) @(negedge clk);

    prev2 = -1;
    acc2 = 0;
    cl2_seen = 0;
    @(posedge clk); #1;
    bus2.in_valid = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("dut2 accepts >= 4", (acc2 >= 4), 1);
`ifndef MSKAES_SEQ_CLEANING_EN
    chk("dut2 cleaning_on never set", cl2_seen, 0);
`endif
    chk("dut2 scoreboard drained", exp_out2.size(), 0);
    chk("main scoreboard drained", exp_out.size() + exp_rnd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
